// File: rtl/count_display_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | count_display_if : load/convert/display signal bundle  | rev 1.0      |
// +-----------------------------------------------------------------------+
interface count_display_if;
  logic [6:0]  count_in;
  logic        load;
  logic        busy;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;

  modport master (output count_in, load, input busy, bcd, seg, an);
  modport slave  (input count_in, load, output busy, bcd, seg, an);
endinterface
`default_nettype wire

// File: rtl/count_display.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | count_display : 7-bit binary to BCD, 3-digit multiplexed display      |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module count_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  wire logic     clk,
  input  wire logic     rst,
  count_display_if.slave bus
);

  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CONVERT = 1'b1;
  localparam logic [2:0] c_last_step = 3'd6;

  logic [0:0]         r_state, w_next_state;
  logic [6:0]         r_bin;
  logic [11:0]        r_scratch;
  logic [2:0]         r_step;
  logic [11:0]        r_bcd;
  logic [PRESC_W-1:0] r_presc;
  logic [1:0]         r_digit;
  logic               w_busy, w_done;
  logic [11:0]        w_adj, w_shift;
  logic [3:0]         w_nibble;
  logic               w_blank;
  logic [6:0]         w_seg;
  logic [2:0]         w_an;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.load) w_next_state = S_CONVERT;
      S_CONVERT: if (w_done)   w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy = (r_state == S_CONVERT);
    w_done = w_busy && (r_step == c_last_step);
  end

  assign w_adj   = {adj3(r_scratch[11:8]), adj3(r_scratch[7:4]), adj3(r_scratch[3:0])};
  assign w_shift = {w_adj[10:0], r_bin[6]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_step    <= '0;
      r_bcd     <= '0;
    end else if (r_state == S_IDLE) begin
      if (bus.load) begin
        r_bin     <= bus.count_in;
        r_scratch <= '0;
        r_step    <= '0;
      end
    end else begin
      r_scratch <= w_shift;
      r_bin     <= {r_bin[5:0], 1'b0};
      r_step    <= r_step + 3'd1;
      if (w_done) r_bcd <= w_shift;
    end
  end

  // Scan prescaler and digit index run independently of the converter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (r_presc == PRESC_W'(REFRESH_DIV - 1)) begin
      r_presc <= '0;
      r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  always_comb begin
    w_nibble = r_bcd[3:0];
    w_blank  = 1'b0;
    case (r_digit)
      2'd0: w_nibble = r_bcd[3:0];
      2'd1: begin
        w_nibble = r_bcd[7:4];
        w_blank  = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        w_nibble = r_bcd[11:8];
        w_blank  = (r_bcd[11:8] == 4'd0);
      end
      default: w_blank = 1'b1;
    endcase

    case (w_nibble)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b1111111;
    endcase

    w_an = ~(3'b001 << r_digit);
    if (w_blank) begin
      w_seg = 7'b1111111;
      w_an  = 3'b111;
    end
  end

  assign bus.busy = w_busy;
  assign bus.bcd  = r_bcd;
  assign bus.seg  = w_seg;
  assign bus.an   = w_an;

endmodule
`default_nettype wire
